// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the multiply/divide unit
package muldiv_pkg;

  localparam int MULDIV_N = 32;
  localparam int CNT_W    = $clog2(MULDIV_N);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  // Signed ops are the even encodings
  function automatic logic op_is_signed(input op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negate (abs on the way in, sign restore on the way out)
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  // Negating -2^(W-1) wraps back to itself, which read as unsigned is the correct magnitude
  assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiply / restoring divide, one bit per clock; MULDIV_DIV_EN enables the divider
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int N = MULDIV_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_by_zero
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [N-1:0]     opb_q, opb_d;
  logic [N-1:0]     hi_q, hi_d;
  logic [N-1:0]     lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  op_t              op_in;
  logic             a_neg, b_neg;
  logic [N-1:0]     abs_a, abs_b;
  logic [2*N-1:0]   prod_fix;
  logic [N:0]       msum;
  logic [2*N-1:0]   mul_next;

  assign op_in = op_t'(op);
  assign a_neg = op_is_signed(op_in) & a[N-1];
  assign b_neg = op_is_signed(op_in) & b[N-1];

  muldiv_signfix #(.W(N)) u_abs_a (.val_i(a), .neg_i(a_neg), .res_o(abs_a));
  muldiv_signfix #(.W(N)) u_abs_b (.val_i(b), .neg_i(b_neg), .res_o(abs_b));
  muldiv_signfix #(.W(2*N)) u_fix_prod (.val_i(acc_q), .neg_i(neg_q), .res_o(prod_fix));

`ifdef MULDIV_DIV_EN
  logic         rneg_q, rneg_d;
  logic         zero_q, zero_d;
  logic [N-1:0] quot_fix, rem_fix;
  logic [N:0]   rshift, rdiff;
  logic [2*N-1:0] div_next;

  muldiv_signfix #(.W(N)) u_fix_quot (.val_i(acc_q[N-1:0]), .neg_i(neg_q), .res_o(quot_fix));
  muldiv_signfix #(.W(N)) u_fix_rem (.val_i(acc_q[2*N-1:N]), .neg_i(rneg_q), .res_o(rem_fix));

  // Restoring divide step: shift remainder left by one dividend bit, subtract divisor if it fits
  always_comb begin
    rshift = {acc_q[2*N-1:N], acc_q[N-1]};
    rdiff  = rshift - {1'b0, opb_q};
    if (!rdiff[N]) begin
      div_next = {rdiff[N-1:0], acc_q[N-2:0], 1'b1};
    end else begin
      div_next = {rshift[N-1:0], acc_q[N-2:0], 1'b0};
    end
  end
`endif

  // Shift-add multiply step: conditionally add multiplicand into the upper half, shift right
  always_comb begin
    msum     = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opb_q} : {(N+1){1'b0}});
    mul_next = {msum, acc_q[N-1:1]};
  end

  // Next-state and datapath control for IDLE -> CALC -> FIX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
`ifdef MULDIV_DIV_EN
    rneg_d  = rneg_q;
    zero_d  = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          div_d = op_is_div(op_in);
          neg_d = a_neg ^ b_neg;
          dbz_d = 1'b0;
          cnt_d = CNT_W'(N - 1);
          if (!op_is_div(op_in)) begin
            opb_d   = abs_a;
            acc_d   = {{N{1'b0}}, abs_b};
            state_d = CALC;
          end else begin
`ifdef MULDIV_DIV_EN
            rneg_d = a_neg;
            if (b == '0) begin
              // Keep the raw dividend; it is returned untouched in hi
              acc_d   = {{N{1'b0}}, a};
              zero_d  = 1'b1;
              state_d = FIX;
            end else begin
              opb_d   = abs_b;
              acc_d   = {{N{1'b0}}, abs_a};
              zero_d  = 1'b0;
              state_d = CALC;
            end
`else
            // No divider: finish immediately so the pipeline is released
            state_d = FIX;
`endif
          end
        end
      end
      CALC: begin
`ifdef MULDIV_DIV_EN
        acc_d = div_q ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!div_q) begin
          hi_d = prod_fix[2*N-1:N];
          lo_d = prod_fix[N-1:0];
        end
`ifdef MULDIV_DIV_EN
        else if (zero_q) begin
          hi_d  = acc_q[N-1:0];
          lo_d  = {N{1'b1}};
          dbz_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any operation without writing hi/lo
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef MULDIV_DIV_EN
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (divide checks follow MULDIV_DIV_EN)
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  int   lat;
  logic busy_ok;
  logic done_seen;

  muldiv_unit #(.N(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op from a negedge, optionally pulse a stray start at edge E<pulse_at>,
  // and count edges from E0 until done is seen (bounded).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int pulse_at, output int l, output logic bok);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    l = 0;
    bok = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h5A5A5A5A;
    while (done !== 1'b1 && l < 100) begin
      if (busy !== 1'b1) bok = 1'b0;
      if (pulse_at != 0 && l == pulse_at - 1) begin
        start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd0;
      end
      @(posedge clk);
      l++;
      @(negedge clk);
      start = 1'b0;
    end
    if (busy !== 1'b0) bok = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;

    // Abort a MULT with reset sampled at E10
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_nodone", {63'd0, done_seen}, 64'd0);

    // MULTU max x max
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, busy_ok);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_busy", {63'd0, busy_ok}, 64'd1);
    chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

    // MULT -3 * 7, started in the done cycle of the previous op
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, 0, lat, busy_ok);
    chk("mult_neg_lat", 64'(lat), 64'd33);
    chk("mult_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    // MULT -2^31 * 2
    run_op(2'b00, 32'h80000000, 32'd2, 0, lat, busy_ok);
    chk("mult_min_hilo", {hi, lo}, 64'hFFFFFFFF_00000000);

    // MULT -1 * -1
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, busy_ok);
    chk("mult_m1m1_hilo", {hi, lo}, 64'h00000000_00000001);

    // MULTU 2^16 * 2^16 with a stray DIVU-by-zero start at E5
    run_op(2'b01, 32'h00010000, 32'h00010000, 5, lat, busy_ok);
    chk("ignore_lat", 64'(lat), 64'd33);
    chk("ignore_busy", {63'd0, busy_ok}, 64'd1);
    chk("ignore_hilo", {hi, lo}, 64'h00000001_00000000);
    chk("ignore_dbz", {63'd0, div_by_zero}, 64'd0);

`ifdef MULDIV_DIV_EN
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, lat, busy_ok);
    chk("div_neg_lat", 64'(lat), 64'd33);
    chk("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    run_op(2'b10, 32'd7, 32'hFFFFFFFE, 0, lat, busy_ok);
    chk("div_negb_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);

    run_op(2'b11, 32'd100, 32'd7, 0, lat, busy_ok);
    chk("divu_hilo", {hi, lo}, 64'h00000002_0000000E);

    run_op(2'b11, 32'h00001234, 32'd0, 0, lat, busy_ok);
    chk("dbz_lat", 64'(lat), 64'd1);
    chk("dbz_hilo", {hi, lo}, 64'h00001234_FFFFFFFF);
    chk("dbz_flag", {63'd0, div_by_zero}, 64'd1);

    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, lat, busy_ok);
    chk("ovf_lat", 64'(lat), 64'd33);
    chk("ovf_hilo", {hi, lo}, 64'h00000000_80000000);
    chk("ovf_dbz_clr", {63'd0, div_by_zero}, 64'd0);

    run_op(2'b10, 32'hFFFFFFFB, 32'd0, 0, lat, busy_ok);
    chk("sdbz_hilo", {hi, lo}, 64'hFFFFFFFB_FFFFFFFF);
    chk("sdbz_flag", {63'd0, div_by_zero}, 64'd1);
`else
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, lat, busy_ok);
    chk("nodiv_lat", 64'(lat), 64'd1);
    chk("nodiv_hilo", {hi, lo}, 64'h00000001_00000000);
    chk("nodiv_dbz", {63'd0, div_by_zero}, 64'd0);

    run_op(2'b11, 32'h00001234, 32'd0, 0, lat, busy_ok);
    chk("nodivu_lat", 64'(lat), 64'd1);
    chk("nodivu_hilo", {hi, lo}, 64'h00000001_00000000);
    chk("nodivu_dbz", {63'd0, div_by_zero}, 64'd0);
`endif

    // MULTU by zero after everything else
    run_op(2'b01, 32'd0, 32'd12345, 0, lat, busy_ok);
    chk("multu_zero_hilo", {hi, lo}, 64'd0);

    // hi/lo hold once idle
    repeat (3) @(negedge clk);
    chk("hold_hilo", {hi, lo}, 64'd0);
    chk("hold_done", {63'd0, done}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
